// File: rtl/port_pipe_pkg.sv
// Shared defaults and width helpers for the port_pipe buffer.
package port_pipe_pkg;

  localparam int unsigned DEF_WIDTH    = 32;
  localparam int unsigned DEF_CHANNELS = 1;
  localparam int unsigned DEF_DEPTH    = 2;
  localparam int          DEF_OFFSET   = 2;

  // Pointer width for a DEPTH-entry array; never narrower than one bit.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int unsigned count_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/port_pipe_mem.sv
// DEPTH-entry storage array: one synchronous write port, one asynchronous read port.
module port_pipe_mem
  import port_pipe_pkg::*;
#(
  parameter int unsigned DW    = DEF_WIDTH * DEF_CHANNELS,
  parameter int unsigned DEPTH = DEF_DEPTH,
  localparam int unsigned PW   = ptr_width(DEPTH)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [PW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [PW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/port_pipe.sv
// Multi-lane valid/ready buffer with registered head output.
// Optional build macro PORT_PIPE_OFFSET_EN adds OFFSET to each lane at write time.
module port_pipe
  import port_pipe_pkg::*;
#(
  parameter int unsigned WIDTH    = DEF_WIDTH,
  parameter int unsigned CHANNELS = DEF_CHANNELS,
  parameter int unsigned DEPTH    = DEF_DEPTH,
  parameter int          OFFSET   = DEF_OFFSET
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [CHANNELS*WIDTH-1:0]     in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [CHANNELS*WIDTH-1:0]     out_data,
  output logic [$clog2(DEPTH+1)-1:0]    count
);

  localparam int unsigned PW = ptr_width(DEPTH);
  localparam int unsigned CW = count_width(DEPTH);
  localparam int unsigned DW = CHANNELS * WIDTH;

`ifdef PORT_PIPE_OFFSET_EN
  localparam bit OFFSET_EN = 1'b1;
`else
  localparam bit OFFSET_EN = 1'b0;
`endif
  localparam logic [WIDTH-1:0] LANE_ADD = OFFSET_EN ? WIDTH'(OFFSET) : '0;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [DW-1:0] out_data_q, out_data_d;
  logic [DW-1:0] wr_data, rd_data;
  logic          push, pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign in_ready  = (count_q < CW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign out_data  = out_data_q;
  assign count     = count_q;

  // Lanes are added independently so no carry crosses a lane boundary.
  always_comb begin
    wr_data = '0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      wr_data[k*WIDTH +: WIDTH] = in_data[k*WIDTH +: WIDTH] + LANE_ADD;
    end
  end

  // out_data is a register preloaded with the entry that will be head after
  // this edge; when that slot is being written now, take the write data.
  always_comb begin
    count_d    = count_q;
    wr_ptr_d   = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d   = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    out_data_d = out_data_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
    if (count_d != '0) begin
      out_data_d = (push && (rd_ptr_d == wr_ptr_q)) ? wr_data : rd_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      out_data_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      out_data_q <= out_data_d;
    end
  end

  port_pipe_mem #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (push),
    .wr_addr (wr_ptr_q),
    .wr_data (wr_data),
    .rd_addr (rd_ptr_d),
    .rd_data (rd_data)
  );

endmodule
